mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// and a load/store requester. Data wins collisions until a waiting fetch has
// been passed over STARVE_LIMIT times; a fetch can be cancelled by a flush,
// in which case its memory response is swallowed without a ready pulse.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_flush,
    output logic        fetch_ready,
    output logic [31:0] fetch_rdata,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic        data_ready,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // Counter wide enough to hold STARVE_LIMIT itself (saturation value).
    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              drop_q, drop_d;

    logic              grant_data_s;
    logic              grant_fetch_s;
    logic [CNT_W-1:0]  starve_inc_s;

    // Grant decision: data first unless a waiting fetch has been starved long enough.
    always_comb begin
        grant_data_s  = 1'b0;
        grant_fetch_s = 1'b0;
        if ((state_q == ST_IDLE) && cpu_en) begin
            grant_data_s  = data_req && (!fetch_req || (starve_cnt_q < CNT_LIMIT));
            grant_fetch_s = !grant_data_s && fetch_req && !fetch_flush;
        end else begin
            grant_data_s  = 1'b0;
            grant_fetch_s = 1'b0;
        end
        if (starve_cnt_q == CNT_LIMIT) begin
            starve_inc_s = starve_cnt_q;
        end else begin
            starve_inc_s = starve_cnt_q + CNT_ONE;
        end
    end

    // Next-state logic: FSM transitions, request latching, starvation and drop tracking.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        starve_cnt_d = starve_cnt_q;
        drop_d       = drop_q;
        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (grant_data_s) begin
                    state_d     = ST_DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = data_we;
                    mem_addr_d  = data_addr;
                    mem_wdata_d = data_wdata;
                    mem_wstrb_d = data_wstrb;
                    if (fetch_req) begin
                        starve_cnt_d = starve_inc_s;
                    end else begin
                        starve_cnt_d = CNT_ZERO;
                    end
                end else if (grant_fetch_s) begin
                    state_d      = ST_FETCH;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = fetch_addr;
                    mem_wdata_d  = 32'h0000_0000;
                    mem_wstrb_d  = 4'h0;
                    starve_cnt_d = CNT_ZERO;
                end else if (!fetch_req) begin
                    starve_cnt_d = CNT_ZERO;
                end else begin
                    starve_cnt_d = starve_cnt_q;
                end
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                end else if (fetch_flush) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
            end
            ST_DATA: begin
                if (mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                drop_d    = 1'b0;
            end
        endcase
    end

    // State and memory-side registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_wdata_q  <= 32'h0000_0000;
            mem_wstrb_q  <= 4'h0;
            starve_cnt_q <= CNT_ZERO;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            starve_cnt_q <= starve_cnt_d;
            drop_q       <= drop_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

    // Completion pulses come straight from the memory ack so a same-cycle ack costs no latency.
    assign data_ready  = (state_q == ST_DATA) && mem_ack;
    assign data_rdata  = mem_rdata;
    assign fetch_ready = (state_q == ST_FETCH) && mem_ack && !drop_q && !fetch_flush;
    assign fetch_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// protocol-following phase, all compared against a transaction-level model.
module tb_mem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int BUSY_NONE  = 0;
    localparam int BUSY_FETCH = 1;
    localparam int BUSY_DATA  = 2;

    logic        clk;
    logic        reset;
    logic        cpu_en;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_flush;
    logic        fetch_ready;
    logic [31:0] fetch_rdata;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_ready;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int chk_cnt = 0;
    int err_cnt = 0;

    // Reference model: who owns the memory port and the transaction it carries.
    int          m_busy;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    int          m_starve;
    logic        m_drop;

    logic e_fr, e_dr, exp_fr_q, exp_dr_q, obs_fr, obs_dr;

    mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset), .cpu_en(cpu_en),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
        .fetch_ready(fetch_ready), .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_ready(data_ready), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_busy = BUSY_NONE; m_req = 1'b0; m_we = 1'b0; m_addr = 32'h0;
        m_wdata = 32'h0; m_wstrb = 4'h0; m_starve = 0; m_drop = 1'b0;
    endfunction

    // One clock edge of the arbitration rules, using the inputs present at that edge.
    function automatic void model_step();
        if (!reset) begin
            model_reset();
        end else if (m_busy == BUSY_NONE) begin
            m_drop = 1'b0;
            if (cpu_en && data_req && (!fetch_req || m_starve < STARVE_LIMIT)) begin
                m_busy = BUSY_DATA; m_req = 1'b1; m_we = data_we; m_addr = data_addr;
                m_wdata = data_wdata; m_wstrb = data_wstrb;
                m_starve = fetch_req ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT) : 0;
            end else if (cpu_en && fetch_req && !fetch_flush) begin
                m_busy = BUSY_FETCH; m_req = 1'b1; m_we = 1'b0; m_addr = fetch_addr;
                m_wdata = 32'h0; m_wstrb = 4'h0; m_starve = 0;
            end else if (!fetch_req) begin
                m_starve = 0;
            end
        end else if (mem_ack) begin
            m_busy = BUSY_NONE; m_req = 1'b0; m_drop = 1'b0;
        end else if (m_busy == BUSY_FETCH && fetch_flush) begin
            m_drop = 1'b1;
        end
    endfunction

    task automatic check_regs();
        check_val("mem_req",   32'(mem_req),   32'(m_req));
        check_val("mem_we",    32'(mem_we),    32'(m_we));
        check_val("mem_addr",  mem_addr,       m_addr);
        check_val("mem_wdata", mem_wdata,      m_wdata);
        check_val("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
    endtask

    // One cycle: check ready outputs mid-cycle, advance across the edge, check registers.
    task automatic tick();
        #2;
        e_fr = (m_busy == BUSY_FETCH) && mem_ack && !m_drop && !fetch_flush;
        e_dr = (m_busy == BUSY_DATA) && mem_ack;
        obs_fr = fetch_ready;
        obs_dr = data_ready;
        check_val("fetch_ready", 32'(fetch_ready), 32'(e_fr));
        check_val("data_ready",  32'(data_ready),  32'(e_dr));
        if (e_fr) check_val("fetch_rdata", fetch_rdata, mem_rdata);
        if (e_dr) check_val("data_rdata",  data_rdata,  mem_rdata);
        exp_fr_q = e_fr;
        exp_dr_q = e_dr;
        @(posedge clk);
        model_step();
        #1;
        check_regs();
    endtask

    task automatic idle_inputs();
        cpu_en = 1'b1; fetch_req = 1'b0; fetch_addr = 32'h0; fetch_flush = 1'b0;
        data_req = 1'b0; data_we = 1'b0; data_addr = 32'h0; data_wdata = 32'h0;
        data_wstrb = 4'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    endtask

    // Requesters and memory that obey the hold-until-ready protocol.
    task automatic drive_random();
        if (fetch_flush || exp_fr_q) fetch_req = 1'b0;
        if (!fetch_req && $urandom_range(0, 2) == 0) begin
            fetch_req = 1'b1;
            fetch_addr = $urandom & 32'hFFFF_FFFC;
        end
        fetch_flush = ($urandom_range(0, 11) == 0);
        if (exp_dr_q) data_req = 1'b0;
        if (!data_req && $urandom_range(0, 2) == 0) begin
            data_req = 1'b1;
            data_we = 1'($urandom_range(0, 1));
            data_addr = $urandom;
            data_wdata = $urandom;
            data_wstrb = 4'($urandom_range(0, 15));
        end
        cpu_en = ($urandom_range(0, 9) != 0);
        mem_ack = ($urandom_range(0, 9) < 4);
        mem_rdata = $urandom;
    endtask

    initial begin
        int cnt_d;
        logic seen_f;
        idle_inputs();
        reset = 1'b0;
        exp_fr_q = 1'b0; exp_dr_q = 1'b0;
        model_reset();
        tick(); tick();
        check_val("rst_mem_req",  32'(mem_req), 32'h0);
        check_val("rst_mem_addr", mem_addr,     32'h0);
        reset = 1'b1;
        // Ack while idle must be ignored.
        mem_ack = 1'b1; tick(); tick();
        check_val("idle_ack_req", 32'(mem_req), 32'h0);
        mem_ack = 1'b0; tick();

        // Fetch only, ack in the grant cycle.
        fetch_req = 1'b1; fetch_addr = 32'h100;
        tick();
        check_val("t1_addr", mem_addr, 32'h100);
        check_val("t1_we",   32'(mem_we), 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
        tick();
        check_val("t1_fready", 32'(obs_fr), 32'h1);
        idle_inputs(); tick();

        // Collision: data first, then fetch after one idle cycle.
        fetch_req = 1'b1; fetch_addr = 32'h140; data_req = 1'b1; data_addr = 32'h240;
        tick();
        check_val("t2_first_data", mem_addr, 32'h240);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        check_val("t2_dready", 32'(obs_dr), 32'h1);
        data_req = 1'b0; mem_ack = 1'b0;
        tick();
        check_val("t2_then_fetch", mem_addr, 32'h140);
        mem_ack = 1'b1;
        tick();
        idle_inputs(); tick();

        // Starvation: four data grants, then the fetch.
        fetch_req = 1'b1; fetch_addr = 32'h400; data_req = 1'b1; data_addr = 32'h500;
        mem_ack = 1'b1;
        cnt_d = 0; seen_f = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (obs_dr && !seen_f) cnt_d++;
            if (obs_fr) begin
                seen_f = 1'b1;
                fetch_req = 1'b0;
            end
        end
        check_val("t3_data_grants", 32'(cnt_d), 32'd4);
        check_val("t3_fetch_seen",  32'(seen_f), 32'h1);
        idle_inputs(); tick(); tick();

        // Flush of an in-flight fetch; ack 3 cycles later yields no ready.
        fetch_req = 1'b1; fetch_addr = 32'h200;
        tick();
        fetch_flush = 1'b1;
        tick();
        fetch_flush = 1'b0; fetch_req = 1'b0;
        tick(); tick();
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        check_val("t4_no_fready", 32'(obs_fr), 32'h0);
        check_val("t4_idle",      32'(mem_req), 32'h0);
        mem_ack = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h204;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0600_0D00;
        tick();
        check_val("t4_next_fready", 32'(obs_fr), 32'h1);
        idle_inputs(); tick();

        // Store with five wait states.
        data_req = 1'b1; data_we = 1'b1; data_wstrb = 4'h3; data_addr = 32'h600;
        data_wdata = 32'hDEAD_BEEF;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("t5_req",   32'(mem_req),   32'h1);
            check_val("t5_addr",  mem_addr,       32'h600);
            check_val("t5_wstrb", 32'(mem_wstrb), 32'h3);
            check_val("t5_wdata", mem_wdata,      32'hDEAD_BEEF);
        end
        mem_ack = 1'b1;
        tick();
        check_val("t5_dready", 32'(obs_dr), 32'h1);
        idle_inputs(); tick();

        // cpu_en falls mid-transaction: finish it, then stay idle until re-enabled.
        data_req = 1'b1; data_addr = 32'h300;
        tick();
        cpu_en = 1'b0;
        tick();
        mem_ack = 1'b1;
        tick();
        check_val("t7_dready", 32'(obs_dr), 32'h1);
        mem_ack = 1'b0; data_addr = 32'h304;
        tick(); tick();
        check_val("t7_hold_idle", 32'(mem_req), 32'h0);
        cpu_en = 1'b1;
        tick();
        check_val("t7_regrant", mem_addr, 32'h304);
        mem_ack = 1'b1;
        tick();
        idle_inputs(); tick();

        // Reset mid-DATA with the starvation counter at its limit.
        fetch_req = 1'b1; fetch_addr = 32'h700; data_req = 1'b1; data_addr = 32'h800;
        mem_ack = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check_val("t6_pre_data", mem_addr, 32'h800);
        reset = 1'b0;
        #1;
        model_reset();
        check_val("t6_async_req", 32'(mem_req),    32'h0);
        check_val("t6_no_dready", 32'(data_ready), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        check_val("t6_starve_clr", mem_addr, 32'h800);
        idle_inputs(); tick(); tick();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive_random();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
